// File: rtl/jt900h_intctl_pkg.sv
// jt900h_intctl_pkg
// Shared definitions for the jt900h interrupt controller: register word
// addresses, source counts, the presentation state type and a helper that
// turns a source index into its vector address.
package jt900h_intctl_pkg;

    localparam logic [1:0] INT_PEND = 2'd0;
    localparam logic [1:0] INT_MASK = 2'd1;
    localparam logic [1:0] INT_LVL  = 2'd2;
    localparam logic [1:0] INT_TMR  = 2'd3;

    localparam int NSRC    = 4;
    localparam int TMR_BIT = 4;
    localparam int NPEND   = NSRC + 1;

    typedef logic [2:0]             lvl_t;
    typedef lvl_t [NPEND-1:0]       lvl_arr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } pres_st_t;

    // Each source owns a 4-byte vector slot above the base.
    function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [2:0] idx);
        return base + {3'd0, idx, 2'd0};
    endfunction

endpackage

// File: rtl/jt900h_intctl_if.sv
// jt900h_intctl_if
// Bus and CPU-side signals of the interrupt controller.
//   cen              clock enable
//   cs/addr/din/we   register write/select, dout combinational read data
//   src              external interrupt sources (rising-edge sensitive)
//   intrq/irq        presented level and request-valid
//   irq_ack          CPU acknowledge
//   int_addr         vector of the presented source
// master: the CPU/SoC side, slave: the controller.
interface jt900h_intctl_if;
    import jt900h_intctl_pkg::*;

    logic            cen;
    logic            cs;
    logic [1:0]      addr;
    logic [15:0]     din;
    logic [1:0]      we;
    logic [15:0]     dout;
    logic [NSRC-1:0] src;
    logic [2:0]      intrq;
    logic            irq;
    logic            irq_ack;
    logic [7:0]      int_addr;

    modport master (
        output cen, cs, addr, din, we, src, irq_ack,
        input  dout, intrq, irq, int_addr
    );

    modport slave (
        input  cen, cs, addr, din, we, src, irq_ack,
        output dout, intrq, irq, int_addr
    );

endinterface

// File: rtl/jt900h_intctl_arb.sv
// jt900h_intctl_arb
// Combinational priority encoder.
//   i_req  pending & mask, one bit per source
//   i_lvl  3-bit level per source
//   o_hit  some candidate exists
//   o_idx  winning source index
//   o_lvl  winning level
// Highest level wins; ties go to the lowest index; level 0 never wins.
module jt900h_intctl_arb
    import jt900h_intctl_pkg::*;
(
    input  logic [NPEND-1:0] i_req,
    input  lvl_arr_t         i_lvl,
    output logic             o_hit,
    output logic [2:0]       o_idx,
    output lvl_t             o_lvl
);

    logic       w_hit;
    logic [2:0] w_idx;
    lvl_t       w_lvl;

    // Strict '>' keeps the earlier (lower) index on a tie, and starting the
    // best level at 0 drops level-0 sources without a separate test.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        w_lvl = 3'd0;
        for (int i = 0; i < NPEND; i++) begin
            if (i_req[i] && (i_lvl[i] > w_lvl)) begin
                w_hit = 1'b1;
                w_idx = 3'(i);
                w_lvl = i_lvl[i];
            end
        end
    end

    assign o_hit = w_hit;
    assign o_idx = w_idx;
    assign o_lvl = w_lvl;

endmodule

// File: rtl/jt900h_intctl.sv
// jt900h_intctl
// Memory-mapped interrupt controller in front of the jt900h CPU interrupt
// pins: register file, source edge detect, one-shot countdown timer and the
// presentation/acknowledge logic.
//   clk   clock
//   rst   synchronous active-low reset (acts regardless of cen)
//   bus   jt900h_intctl_if slave modport (register bus, sources, CPU pins)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | nothing presented; arbitrate every cen cycle
// ST_REQ  | irq=1, cur/intrq/int_addr frozen until irq_ack
module jt900h_intctl
    import jt900h_intctl_pkg::*;
#(
    parameter int         TIMW  = 8,
    parameter logic [7:0] VBASE = 8'h20
) (
    input  logic             clk,
    input  logic             rst,
    jt900h_intctl_if.slave   bus
);

    logic [NPEND-1:0] r_pend;
    logic [NPEND-1:0] r_mask;
    logic [11:0]      r_lvl;
    logic [TIMW-1:0]  r_tcnt;
    lvl_t             r_tlvl;
    logic [NSRC-1:0]  r_src_l;
    logic [2:0]       r_cur;
    lvl_t             r_intrq;
    logic [7:0]       r_int_addr;
    pres_st_t         r_state;

    pres_st_t         w_state_nxt;
    logic             w_load;
    logic             w_hit;
    logic [2:0]       w_idx;
    lvl_t             w_win_lvl;
    lvl_arr_t         w_lvl_arr;
    logic [15:0]      w_dout;

    logic w_wr_pend, w_wr_mask, w_wr_lvl, w_wr_tmr, w_tmr_zero, w_tmr_exp, w_ack;
    logic [NPEND-1:0] w_set, w_clr, w_pend_nxt;

    assign w_wr_pend  = bus.cs && bus.we[0] && (bus.addr == INT_PEND);
    assign w_wr_mask  = bus.cs && bus.we[0] && (bus.addr == INT_MASK);
    assign w_wr_lvl   = bus.cs && (&bus.we) && (bus.addr == INT_LVL);
    assign w_wr_tmr   = bus.cs && bus.we[0] && (bus.addr == INT_TMR);
    assign w_tmr_zero = (bus.din[8 +: TIMW] == '0);
    assign w_ack      = bus.irq_ack && (r_state == ST_REQ);

    // A timer write overrides the running count, so it also suppresses
    // the expiry that would have happened on this edge.
    assign w_tmr_exp  = (r_tcnt == TIMW'(1)) && !w_wr_tmr;

    assign w_set = {w_tmr_exp, bus.src & ~r_src_l};
    assign w_clr = (w_wr_pend ? bus.din[NPEND-1:0] : '0)
                 | (w_ack ? (NPEND'(1) << r_cur) : '0)
                 | ((w_wr_tmr && w_tmr_zero) ? (NPEND'(1) << TMR_BIT) : '0);

    // Set after clear: a new edge always survives a same-cycle clear.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

    assign w_lvl_arr = {r_tlvl, r_lvl[11:9], r_lvl[8:6], r_lvl[5:3], r_lvl[2:0]};

    jt900h_intctl_arb u_arb (
        .i_req (r_pend & r_mask),
        .i_lvl (w_lvl_arr),
        .o_hit (w_hit),
        .o_idx (w_idx),
        .o_lvl (w_win_lvl)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_lvl   <= '0;
            r_src_l <= '0;
        end else if (bus.cen) begin
            r_src_l <= bus.src;
            r_pend  <= w_pend_nxt;
            if (w_wr_mask) r_mask <= bus.din[NPEND-1:0];
            if (w_wr_lvl)  r_lvl  <= bus.din[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tcnt <= '0;
            r_tlvl <= '0;
        end else if (bus.cen) begin
            if (w_wr_tmr) begin
                r_tcnt <= bus.din[8 +: TIMW];
                r_tlvl <= bus.din[2:0];
            end else if (r_tcnt != '0) begin
                r_tcnt <= r_tcnt - TIMW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else if (bus.cen) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_state_nxt = ST_REQ;
                    w_load      = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur      <= '0;
            r_intrq    <= '0;
            r_int_addr <= '0;
        end else if (bus.cen) begin
            if (w_load) begin
                r_cur      <= w_idx;
                r_intrq    <= w_win_lvl;
                r_int_addr <= vec_addr(VBASE, w_idx);
            end else if (w_ack) begin
                r_intrq    <= '0;
                r_int_addr <= '0;
            end
        end
    end

    always_comb begin
        w_dout = 16'd0;
        if (bus.cs) begin
            case (bus.addr)
                INT_PEND: w_dout = {11'd0, r_pend};
                INT_MASK: w_dout = {11'd0, r_mask};
                INT_LVL:  w_dout = {4'd0, r_lvl};
                INT_TMR:  w_dout = 16'({r_tcnt, 5'd0, r_tlvl});
                default:  w_dout = 16'd0;
            endcase
        end
    end

    assign bus.dout     = w_dout;
    assign bus.irq      = (r_state == ST_REQ);
    assign bus.intrq    = r_intrq;
    assign bus.int_addr = r_int_addr;

endmodule
